unidade_controle: RTL
=====================

Name: unidade_controle

Overview:
Multicycle control unit for processador_multiciclo. It owns the instruction register and the T0..T3 timestep FSM. It drives every register enable, the one-hot bus-source selects and the ALU control, which sequences the 16-bit BusWires datapath through mv, mvi, add and sub. It sits between the external Run/DIN/Done interface and the R0..R7/A/G/ALU datapath.

Parameters:
IR_W, 9, instruction width; format III_XXX_YYY with opcode [8:6], Rx [5:3], Ry [2:0].
DATA_W, 16, width of DIN; only DIN[IR_W-1:0] is captured into IR.

Ports:
Clock  input  1  system clock, rising edge.
Resetn  input  1  asynchronous active-low reset.
Run  input  1  start request, sampled only in T0.
DIN  input  DATA_W  external data/instruction input.
Rin  output  8  one-hot register load enables for R7..R0.
Rout  output  8  one-hot bus-drive selects for R7..R0.
Gout  output  1  G drives BusWires.
DINout  output  1  DIN drives BusWires.
Ain  output  1  load A from the bus.
Gin  output  1  load G from the ALU.
AddSub  output  1  0 = A+Bus, 1 = A-Bus.
IRin  output  1  IR load strobe (observability).
Done  output  1  instruction completes this cycle.
Tstep  output  2  current timestep (00=T0 .. 11=T3).
IR  output  IR_W  current instruction register contents.

Behaviour:
- Reset (Resetn=0, async): Tstep=T0, IR=0. All strobes are 0: Rin, Rout, Gout, DINout, Ain, Gin, AddSub, IRin, Done. Takes effect mid-instruction with no completion; no Done is emitted.
- All strobe outputs are combinational from (Tstep, IR, Run). Tstep and IR are registers.
- T0: IRin=Run. On a rising edge with Run=1, IR<=DIN[8:0] and Tstep<=T1. With Run=0, stay in T0 and hold IR. No other strobes are active in T0.
- T1, opcode 000 (mv Rx,Ry): Rout[Ry]=1, Rin[Rx]=1, Done=1, then go to T0.
- T1, opcode 001 (mvi Rx,#D): DINout=1, Rin[Rx]=1, Done=1, then go to T0. The immediate is the DIN value present during T1.
- T1, opcode 010/011 (add/sub): Rout[Rx]=1, Ain=1, then go to T2.
- T2 (add/sub): Rout[Ry]=1, Gin=1, AddSub=IR[6], then go to T3.
- T3 (add/sub): Gout=1, Rin[Rx]=1, Done=1, then go to T0.
- Opcodes 100..111: no operation. In T1, Done=1 with no strobes active, then go to T0.
- Latency from the Run-sampled edge to Done: mv/mvi/nop take 1 cycle (T1); add/sub take 3 cycles (T3).
- Bus exclusivity invariant: at most one of {Rout[0..7], Gout, DINout} is 1 in any cycle. In T0 and in nop cycles none is 1, and BusWires is don't-care.
- Run while Tstep≠T0 is ignored. IR is only writable in T0.
- Back-to-back: if Run=1 in the cycle after Done (T0), the next fetch happens immediately. The minimum instruction period is 2 cycles (mv) or 4 cycles (add).
- mv Rx,Rx and add Rx,Rx are legal: the same index appears in both Rin and Rout, or in Rout in T1 and T2.
- Rin and Rout are never multi-hot.
- Tstep never reaches T2 or T3 for mv, mvi or nop. An illegal state encoding is impossible with a 2-bit counter covering all 4 values.

Decomposition:
- Package controle_pkg holds:
  - opcode constants OP_MV=3'b000, OP_MVI=3'b001, OP_ADD=3'b010, OP_SUB=3'b011;
  - timestep constants T0..T3;
  - field-position constants for opcode, Rx and Ry.
- Sub-module decodificador_3_8 (3-bit input plus enable, one-hot 8-bit output). It is instantiated twice, once for Rin and once for Rout; the enable carries the per-state gating.

Test Plan:
- Reset mid-add: reset asserted in T2 -> Tstep=00 immediately, async and before the next edge; all strobes 0; IR=0; no Done.
- mvi R0: DIN=9'b001_000_000 with Run=1 for one cycle, then DIN=16'h00A5 -> T1 shows DINout=1, Rin=8'b0000_0001, Done=1; next cycle Tstep=T0.
- mv R3,R5: IR=000_011_101 -> T1 shows Rout=8'b0010_0000, Rin=8'b0000_1000, Done=1; total 2 cycles.
- sub R2,R7: IR=011_010_111 -> T1 Rout=8'b0000_0100 with Ain; T2 Rout=8'b1000_0000 with Gin and AddSub=1; T3 Gout with Rin=8'b0000_0100 and Done; AddSub=0 for the add variant 010_010_111.
- Run ignored: pulse Run=1 with a new DIN during T2 of an add -> IR unchanged, sequence completes in T3; then Run held high -> IR reloads in the cycle after Done.
- Opcode 110 and the bus-exclusivity invariant: IR=110_001_001 -> Done=1 in T1 with all strobes 0; an assertion on every cycle of all tests checks popcount(Rout)+Gout+DINout ≤ 1, popcount(Rin) ≤ 1 and popcount(Rout) ≤ 1.

Source files
------------

// File: rtl/controle_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : controle_pkg
//  Purpose   : Shared types and constants for the multicycle control unit:
//              timestep encoding, opcodes and instruction field positions.
//  Revision  : 1.0 - initial release
// ============================================================================
package controle_pkg;

  // Timestep encoding; the 2-bit counter covers every value, so no illegal state exists
  typedef enum logic [1:0] {
    T0 = 2'b00,
    T1 = 2'b01,
    T2 = 2'b10,
    T3 = 2'b11
  } tstep_t;

  // Opcodes, instruction bits [8:6]
  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  // Field positions inside the III_XXX_YYY instruction word
  localparam int OP_MSB = 8;
  localparam int OP_LSB = 6;
  localparam int RX_MSB = 5;
  localparam int RX_LSB = 3;
  localparam int RY_MSB = 2;
  localparam int RY_LSB = 0;

  // add and sub are the only instructions that need T2/T3
  function automatic logic is_alu_op(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage
`default_nettype wire

// File: rtl/decodificador_3_8.sv
`default_nettype none
// ============================================================================
//  Module    : decodificador_3_8
//  Purpose   : 3-to-8 one-hot decoder with enable. A disabled decoder
//              drives all zeros, which is how the control unit gates
//              register enables and bus selects per timestep.
//  Revision  : 1.0 - initial release
// ============================================================================
module decodificador_3_8 (
  input  logic [2:0] sel,
  input  logic       en,
  output logic [7:0] y
);

  // One-hot decode of sel, forced to zero when not enabled
  always_comb begin
    y = 8'b0;
    if (en) begin
      y = 8'b0000_0001 << sel;
    end
  end

endmodule
`default_nettype wire

// File: rtl/unidade_controle.sv
`default_nettype none
// ============================================================================
//  Module    : unidade_controle
//  Purpose   : Multicycle control unit for processador_multiciclo. Holds the
//              instruction register and the T0..T3 timestep counter, and
//              decodes (Tstep, IR, Run) into register enables, one-hot bus
//              selects and ALU control for mv, mvi, add and sub.
//  Revision  : 1.0 - initial release
// ============================================================================
module unidade_controle
  import controle_pkg::*;
#(
  parameter int IR_W   = 9,
  parameter int DATA_W = 16
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Run,
  input  logic [DATA_W-1:0] DIN,
  output logic [7:0]        Rin,
  output logic [7:0]        Rout,
  output logic              Gout,
  output logic              DINout,
  output logic              Ain,
  output logic              Gin,
  output logic              AddSub,
  output logic              IRin,
  output logic              Done,
  output logic [1:0]        Tstep,
  output logic [IR_W-1:0]   IR
);

  tstep_t         state;
  logic [IR_W-1:0] ir_q;

  logic [2:0] opcode;
  logic [2:0] rx;
  logic [2:0] ry;

  logic [2:0] rin_sel;
  logic       rin_en;
  logic [2:0] rout_sel;
  logic       rout_en;

  // Only the low IR_W bits of DIN ever reach IR; the rest is bus data only
  logic unused_din;
  assign unused_din = ^DIN[DATA_W-1:IR_W];

  assign opcode = ir_q[OP_MSB:OP_LSB];
  assign rx     = ir_q[RX_MSB:RX_LSB];
  assign ry     = ir_q[RY_MSB:RY_LSB];

  assign Tstep  = state;
  assign IR     = ir_q;

  // Timestep sequencing and instruction fetch; IR is writable only in T0
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state <= T0;
      ir_q  <= '0;
    end else begin
      case (state)
        T0: begin
          if (Run) begin
            ir_q  <= DIN[IR_W-1:0];
            state <= T1;
          end
        end
        T1: begin
          state <= is_alu_op(opcode) ? T2 : T0;
        end
        T2: begin
          state <= T3;
        end
        T3: begin
          state <= T0;
        end
        default: begin
          state <= T0;
        end
      endcase
    end
  end

  // Strobe decode; Rin/Rout selection is routed through the gated decoders
  always_comb begin
    rin_sel  = 3'd0;
    rin_en   = 1'b0;
    rout_sel = 3'd0;
    rout_en  = 1'b0;
    Gout     = 1'b0;
    DINout   = 1'b0;
    Ain      = 1'b0;
    Gin      = 1'b0;
    AddSub   = 1'b0;
    IRin     = 1'b0;
    Done     = 1'b0;

    case (state)
      T0: begin
        // Held low while in reset so no strobe is visible during reset
        IRin = Run & Resetn;
      end
      T1: begin
        case (opcode)
          OP_MV: begin
            rout_sel = ry;
            rout_en  = 1'b1;
            rin_sel  = rx;
            rin_en   = 1'b1;
            Done     = 1'b1;
          end
          OP_MVI: begin
            DINout  = 1'b1;
            rin_sel = rx;
            rin_en  = 1'b1;
            Done    = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            rout_sel = rx;
            rout_en  = 1'b1;
            Ain      = 1'b1;
          end
          default: begin
            // Unused opcodes retire as a no-op with no bus activity
            Done = 1'b1;
          end
        endcase
      end
      T2: begin
        rout_sel = ry;
        rout_en  = 1'b1;
        Gin      = 1'b1;
        AddSub   = ir_q[OP_LSB];
      end
      T3: begin
        Gout    = 1'b1;
        rin_sel = rx;
        rin_en  = 1'b1;
        Done    = 1'b1;
      end
      default: begin
        Done = 1'b0;
      end
    endcase
  end

  decodificador_3_8 u_dec_rin (
    .sel (rin_sel),
    .en  (rin_en),
    .y   (Rin)
  );

  decodificador_3_8 u_dec_rout (
    .sel (rout_sel),
    .en  (rout_en),
    .y   (Rout)
  );

endmodule
`default_nettype wire
